// File: rtl/time_date_setter_pkg.sv
// Shared types, BCD packing indices, reset date and calendar helpers for the
// time/date setting block.
package time_date_setter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_EDIT,
        ST_COMMIT
    } state_t;

    typedef enum logic [2:0] {
        FLD_HOUR  = 3'd0,
        FLD_MIN   = 3'd1,
        FLD_SEC   = 3'd2,
        FLD_DAY   = 3'd3,
        FLD_MONTH = 3'd4,
        FLD_YEAR  = 3'd5
    } field_t;

    // Digit positions in the 56-bit word, digit 0 being the least significant nibble
    localparam int D_YEAR0  = 0;
    localparam int D_YEAR1  = 1;
    localparam int D_YEAR2  = 2;
    localparam int D_YEAR3  = 3;
    localparam int D_MONTH0 = 4;
    localparam int D_MONTH1 = 5;
    localparam int D_DAY0   = 6;
    localparam int D_DAY1   = 7;
    localparam int D_SEC0   = 8;
    localparam int D_SEC1   = 9;
    localparam int D_MIN0   = 10;
    localparam int D_MIN1   = 11;
    localparam int D_HOUR0  = 12;
    localparam int D_HOUR1  = 13;

    localparam int HOUR_LSB    = D_HOUR0 * 4;
    localparam int MIN_LSB     = D_MIN0 * 4;
    localparam int SEC_LSB     = D_SEC0 * 4;
    localparam int DAY_LSB     = D_DAY0 * 4;
    localparam int MONTH_LSB   = D_MONTH0 * 4;
    localparam int YEAR_LO_LSB = D_YEAR0 * 4;
    localparam int YEAR_HI_LSB = D_YEAR2 * 4;

    localparam logic [7:0]  RESET_DAY   = 8'h01;
    localparam logic [7:0]  RESET_MONTH = 8'h01;
    localparam logic [15:0] RESET_YEAR  = 16'h2024;
    localparam logic [55:0] RESET_BCD   = {24'h000000, RESET_DAY, RESET_MONTH, RESET_YEAR};

    function automatic logic [7:0] bcd2bin(input logic [7:0] v);
        return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [7:0] b);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = b / 8'd10;
        ones = b % 8'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    // Binary day count of the given BCD month; an invalid month allows 31
    function automatic logic [7:0] maxday(input logic [7:0] month_bcd, input logic [7:0] year_lo_bcd);
        logic [7:0] y;
        y = bcd2bin(year_lo_bcd);
        case (month_bcd)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'd30;
            8'h02: return ((y % 8'd4) == 8'd0) ? 8'd29 : 8'd28;
            default: return 8'd31;
        endcase
    endfunction

endpackage

// File: rtl/time_date_setter_debounce.sv
// Two-flop synchronizer followed by a symmetric debouncer that emits one
// press pulse per accepted low-to-high transition.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // The counter measures how long the synchronized input has disagreed with the accepted level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 != stable) begin
                if (cnt == LAST) begin
                    cnt    <= '0;
                    stable <= sync_p1;
                    press  <= sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/time_date_setter.sv
// Three-button time/date editor: captures the live BCD value, lets the user
// step through and increment fields, then loads the result back.
module time_date_setter
    import time_date_setter_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int BLINK_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic [55:0] cur_bcd,
    output logic        edit_active,
    output logic [2:0]  field,
    output logic [55:0] set_bcd,
    output logic        load,
    output logic        blank
);
    state_t               state;
    field_t               field_q;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 mode_press;
    logic                 next_press;
    logic                 inc_press;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (.clk(clk), .rst(rst), .btn(btn_mode), .press(mode_press));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (.clk(clk), .rst(rst), .btn(btn_next), .press(next_press));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .press(inc_press));

    // Out-of-range or top-of-range values both restart at the field minimum
    function automatic logic [7:0] inc_bcd2(input logic [7:0] v, input logic [7:0] lo_b, input logic [7:0] hi_b);
        logic [7:0] b;
        b = bcd2bin(v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || b < lo_b || b >= hi_b)
            return bin2bcd(lo_b);
        return bin2bcd(b + 8'd1);
    endfunction

    function automatic logic [55:0] inc_field(input logic [55:0] v, input field_t f);
        logic [55:0] r;
        logic [7:0]  md;
        r = v;
        case (f)
            FLD_HOUR:  r[HOUR_LSB +: 8]  = inc_bcd2(v[HOUR_LSB +: 8], 8'd0, 8'd23);
            FLD_MIN:   r[MIN_LSB +: 8]   = inc_bcd2(v[MIN_LSB +: 8], 8'd0, 8'd59);
            FLD_SEC:   r[SEC_LSB +: 8]   = inc_bcd2(v[SEC_LSB +: 8], 8'd0, 8'd59);
            FLD_DAY:   r[DAY_LSB +: 8]   = inc_bcd2(v[DAY_LSB +: 8], 8'd1,
                                                    maxday(v[MONTH_LSB +: 8], v[YEAR_LO_LSB +: 8]));
            FLD_MONTH: r[MONTH_LSB +: 8] = inc_bcd2(v[MONTH_LSB +: 8], 8'd1, 8'd12);
            FLD_YEAR: begin
                r[YEAR_HI_LSB +: 8] = 8'h20;
                r[YEAR_LO_LSB +: 8] = (v[YEAR_HI_LSB +: 8] != 8'h20) ? 8'h00
                                      : inc_bcd2(v[YEAR_LO_LSB +: 8], 8'd0, 8'd99);
            end
            default: r = v;
        endcase
        // A new month or year can shorten the month, so pull the day back inside it
        if (f == FLD_MONTH || f == FLD_YEAR) begin
            md = maxday(r[MONTH_LSB +: 8], r[YEAR_LO_LSB +: 8]);
            if (bcd2bin(r[DAY_LSB +: 8]) > md)
                r[DAY_LSB +: 8] = bin2bcd(md);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            field_q   <= FLD_HOUR;
            set_bcd   <= RESET_BCD;
            load      <= 1'b0;
            blink_cnt <= '0;
        end else begin
            load      <= 1'b0;
            blink_cnt <= blink_cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (mode_press)
                        state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    set_bcd   <= cur_bcd;
                    field_q   <= FLD_HOUR;
                    blink_cnt <= '0;
                    state     <= ST_EDIT;
                end
                ST_EDIT: begin
                    // Mode outranks next, next outranks inc; losers in the same cycle are dropped
                    if (mode_press) begin
                        set_bcd[SEC_LSB +: 8] <= 8'h00;
                        load                  <= 1'b1;
                        state                 <= ST_COMMIT;
                    end else if (next_press) begin
                        field_q   <= (field_q == FLD_YEAR) ? FLD_HOUR : field_t'(field_q + 3'd1);
                        blink_cnt <= '0;
                    end else if (inc_press) begin
                        set_bcd <= inc_field(set_bcd, field_q);
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign edit_active = (state == ST_EDIT);
    assign field       = field_q;
    assign blank       = edit_active & blink_cnt[BLINK_W-1];

endmodule

// File: tb/tb_time_date_setter.sv
// Directed bench for time_date_setter: button timing, field wrap, calendar
// clamping, press priority, blinking and reset behaviour.
module tb_time_date_setter;

    localparam logic [55:0] RST_VAL = 56'h00000001012024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_inc = 1'b0;
    logic [55:0] cur_bcd = '0;
    logic        edit_active;
    logic [2:0]  field;
    logic [55:0] set_bcd;
    logic        load;
    logic        blank;

    int          errors = 0;
    int          checks = 0;
    int          load_cycles = 0;
    logic [55:0] last_load_bcd = '0;

    time_date_setter #(.DB_CYCLES(4), .BLINK_W(8)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .cur_bcd(cur_bcd), .edit_active(edit_active), .field(field), .set_bcd(set_bcd),
        .load(load), .blank(blank)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        if (load === 1'b1) begin
            load_cycles++;
            last_load_bcd = set_bcd;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic n, input logic i);
        btn_mode = m; btn_next = n; btn_inc = i;
        cyc(8);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        cyc(8);
    endtask

    task automatic test_reset;
        cyc(2);
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL reset_edit: got %b want 0", edit_active); end
        checks++; if (field !== 3'd0) begin errors++; $display("FAIL reset_field: got %0d want 0", field); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", load); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b want 0", blank); end
        checks++; if (set_bcd !== RST_VAL) begin errors++; $display("FAIL reset_bcd: got %h want %h", set_bcd, RST_VAL); end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_idle_ignore;
        cur_bcd = 56'h11223315062033;
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        checks++; if (set_bcd !== RST_VAL) begin errors++; $display("FAIL idle_bcd: got %h want %h", set_bcd, RST_VAL); end
        checks++; if (field !== 3'd0) begin errors++; $display("FAIL idle_field: got %0d want 0", field); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL idle_edit: got %b want 0", edit_active); end
    endtask

    task automatic test_wrap_and_commit;
        int lc0;
        cur_bcd = 56'h23593031122099;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (edit_active !== 1'b1) begin errors++; $display("FAIL capture_edit: got %b want 1", edit_active); end
        checks++; if (set_bcd !== 56'h23593031122099) begin errors++; $display("FAIL capture_bcd: got %h want 23593031122099", set_bcd); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL capture_blank: got %b want 0", blank); end
        // inc latency: pulse after 6 edges, field updated on the 7th
        btn_inc = 1'b1;
        cyc(6);
        checks++; if (set_bcd !== 56'h23593031122099) begin errors++; $display("FAIL inc_early: got %h want 23593031122099", set_bcd); end
        cyc(1);
        checks++; if (set_bcd !== 56'h00593031122099) begin errors++; $display("FAIL inc_hour_wrap: got %h want 00593031122099", set_bcd); end
        btn_inc = 1'b0;
        cyc(8);
        press(1'b0, 1'b1, 1'b0);
        for (int f = 1; f < 6; f++) begin
            press(1'b0, 1'b0, 1'b1);
            if (f == 5) begin
                checks++; if (field !== 3'd5) begin errors++; $display("FAIL field_year: got %0d want 5", field); end
            end
            press(1'b0, 1'b1, 1'b0);
        end
        checks++; if (field !== 3'd0) begin errors++; $display("FAIL field_wrap: got %0d want 0", field); end
        checks++; if (set_bcd !== 56'h00003101012000) begin errors++; $display("FAIL all_wrap: got %h want 00003101012000", set_bcd); end
        lc0 = load_cycles;
        btn_mode = 1'b1;
        cyc(6);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL load_early: got %b want 0", load); end
        cyc(1);
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL load_pulse: got %b want 1", load); end
        checks++; if (set_bcd !== 56'h00000001012000) begin errors++; $display("FAIL commit_bcd: got %h want 00000001012000", set_bcd); end
        cyc(1);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL load_end: got %b want 0", load); end
        btn_mode = 1'b0;
        cyc(8);
        checks++; if (load_cycles !== lc0 + 1) begin errors++; $display("FAIL load_count: got %0d want %0d", load_cycles, lc0 + 1); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL commit_idle: got %b want 0", edit_active); end
        checks++; if (set_bcd !== 56'h00000001012000) begin errors++; $display("FAIL commit_hold: got %h want 00000001012000", set_bcd); end
    endtask

    task automatic test_day_clamp;
        cur_bcd = 56'h12345631012023;
        press(1'b1, 1'b0, 1'b0);
        repeat (4) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++; if (set_bcd !== 56'h12345628022023) begin errors++; $display("FAIL clamp_2023: got %h want 12345628022023", set_bcd); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (last_load_bcd !== 56'h12340028022023) begin errors++; $display("FAIL clamp_load: got %h want 12340028022023", last_load_bcd); end
        cur_bcd = 56'h12345631012024;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (field !== 3'd0) begin errors++; $display("FAIL recapture_field: got %0d want 0", field); end
        repeat (4) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++; if (set_bcd !== 56'h12345629022024) begin errors++; $display("FAIL clamp_2024: got %h want 12345629022024", set_bcd); end
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++; if (set_bcd !== 56'h12345628022025) begin errors++; $display("FAIL clamp_year: got %h want 12345628022025", set_bcd); end
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_out_of_range;
        cur_bcd = 56'h99778800131999;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        for (int f = 1; f < 6; f++) begin
            press(1'b0, 1'b1, 1'b0);
            press(1'b0, 1'b0, 1'b1);
        end
        checks++; if (set_bcd !== 56'h00000001012000) begin errors++; $display("FAIL out_of_range: got %h want 00000001012000", set_bcd); end
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bounce_blink;
        cur_bcd = 56'h07000001012024;
        press(1'b1, 1'b0, 1'b0);
        btn_inc = 1'b1; cyc(1);
        btn_inc = 1'b0; cyc(1);
        btn_inc = 1'b1; cyc(1);
        cyc(10);
        btn_inc = 1'b0;
        cyc(10);
        checks++; if (set_bcd !== 56'h08000001012024) begin errors++; $display("FAIL bounce_once: got %h want 08000001012024", set_bcd); end
        cyc(110);
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blink_on: got %b want 1", blank); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blink_clear: got %b want 0", blank); end
        checks++; if (field !== 3'd1) begin errors++; $display("FAIL bounce_field: got %0d want 1", field); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blank_idle: got %b want 0", blank); end
    endtask

    task automatic test_priority;
        int lc0;
        cur_bcd = 56'h10154515062030;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        lc0 = load_cycles;
        btn_mode = 1'b1; btn_next = 1'b1; btn_inc = 1'b1;
        cyc(7);
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL prio_load: got %b want 1", load); end
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        cyc(9);
        checks++; if (field !== 3'd1) begin errors++; $display("FAIL prio_field: got %0d want 1", field); end
        checks++; if (set_bcd !== 56'h10150015062030) begin errors++; $display("FAIL prio_bcd: got %h want 10150015062030", set_bcd); end
        checks++; if (load_cycles !== lc0 + 1) begin errors++; $display("FAIL prio_count: got %0d want %0d", load_cycles, lc0 + 1); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", edit_active); end
    endtask

    task automatic test_reset_mid_edit;
        int lc0;
        cur_bcd = 56'h11111111112011;
        press(1'b1, 1'b0, 1'b0);
        lc0 = load_cycles;
        btn_inc = 1'b1;
        cyc(7);
        checks++; if (set_bcd !== 56'h12111111112011) begin errors++; $display("FAIL pre_reset_inc: got %h want 12111111112011", set_bcd); end
        cyc(2);
        rst = 1'b1;
        #1;
        checks++; if (set_bcd !== RST_VAL) begin errors++; $display("FAIL midreset_bcd: got %h want %h", set_bcd, RST_VAL); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL midreset_edit: got %b want 0", edit_active); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL midreset_load: got %b want 0", load); end
        btn_inc = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(20);
        checks++; if (load_cycles !== lc0) begin errors++; $display("FAIL midreset_noload: got %0d want %0d", load_cycles, lc0); end
        checks++; if (set_bcd !== RST_VAL) begin errors++; $display("FAIL midreset_after: got %h want %h", set_bcd, RST_VAL); end
        checks++; if (field !== 3'd0) begin errors++; $display("FAIL midreset_field: got %0d want 0", field); end
    endtask

    initial begin
        test_reset;
        test_idle_ignore;
        test_wrap_and_commit;
        test_day_clamp;
        test_out_of_range;
        test_bounce_blink;
        test_priority;
        test_reset_mid_edit;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
